// File: rtl/sbox_word_scheduler.sv
// rtl/sbox_word_scheduler.sv - arbitrates two 32-bit word requesters onto one byte-wide shared S-box
module sbox_word_scheduler #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    input  logic        inv0_i,
    input  logic        inv1_i,
    output logic [1:0]  gnt_o,
    output logic [7:0]  sbox_data_o,
    output logic        sbox_inv_o,
    input  logic [7:0]  sbox_data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        owner_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] word_q;
    logic [31:0] result_q;
    logic        inv_q;
    logic        owner_q;
    logic        last_q;
    logic [1:0]  cnt;
    logic        winner;
    logic        grant;

    // On contention the round-robin mode favours whoever was not served last
    always_comb begin
        winner = 1'b0;
        case (req_i)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = FAIR ? ~last_q : 1'b0;
            default: winner = 1'b0;
        endcase
    end

    assign grant = (state == IDLE) && (req_i != 2'b00);

    always_comb begin
        state_n = state;
        gnt_o   = 2'b00;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_n = BUSY;
                    gnt_o   = winner ? 2'b10 : 2'b01;
                end
            end
            BUSY: begin
                if (cnt == 2'd3) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            word_q   <= '0;
            result_q <= '0;
            inv_q    <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt      <= 2'd0;
        end else begin
            state <= state_n;
            if (grant) begin
                word_q  <= winner ? word1_i : word0_i;
                inv_q   <= winner ? inv1_i : inv0_i;
                owner_q <= winner;
                last_q  <= winner;
                cnt     <= 2'd0;
            end
            // One byte per cycle; untouched bytes keep their previous contents
            if (state == BUSY) begin
                result_q[{cnt, 3'b000} +: 8] <= sbox_data_i;
                cnt                          <= cnt + 2'd1;
            end
        end
    end

    assign sbox_data_o = (state == BUSY) ? word_q[{cnt, 3'b000} +: 8] : 8'h00;
    assign sbox_inv_o  = (state == BUSY) ? inv_q : 1'b0;
    assign valid_o     = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign result_o    = result_q;
    assign owner_o     = owner_q;

endmodule

// File: doc/sbox_word_scheduler.md
SBOX_WORD_SCHEDULER -- requirements
Module: sbox_word_scheduler

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_i  input  2  request per requester; bit 0 = round datapath, bit 1 = key schedule.
REQ-005 word0_i / word1_i  input  32 each  word to substitute for requester 0 / 1.
REQ-006 inv0_i / inv1_i  input  1 each  1 = inverse S-box, 0 = forward S-box, per requester.
REQ-007 gnt_o  output  2  one-hot acceptance strobe; bit n set in the cycle requester n's word is captured.
REQ-008 sbox_data_o  output  8  byte driven to the shared combinational S-box.
REQ-009 sbox_inv_o  output  1  direction select driven to the shared S-box.
REQ-010 sbox_data_i  input  8  substituted byte returned combinationally by the shared S-box.
REQ-011 valid_o  output  1  result_o and owner_o are valid.
REQ-012 ready_i  input  1  consumer accepts the result when valid_o and ready_i are both high.
REQ-013 result_o  output  32  substituted word.
REQ-014 owner_o  output  1  index of the requester that owns result_o.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017 In IDLE with req_i nonzero, gnt_o SHALL be asserted combinationally in the same cycle; the winner's word, inv bit and index are latched on that edge; next state is BUSY with byte counter 0.
REQ-018 In IDLE with req_i == 0, and in BUSY or DONE regardless of req_i, gnt_o SHALL be 0.
REQ-019 FAIR=1, both requesting: the grant goes to the requester not most recently granted. Single requester: it wins. The last-grant pointer updates only on a grant.
REQ-020 FAIR=0: requester 0 SHALL win whenever req_i[0] is high.
REQ-021 In BUSY, sbox_data_o SHALL equal latched byte[cnt] (byte 0 = bits 7:0 first) and sbox_inv_o SHALL equal the latched inv bit.
REQ-022 Each BUSY edge SHALL write sbox_data_i into result byte[cnt] and increment cnt (2-bit); after the cnt==3 edge the state becomes DONE.
REQ-023 Outside BUSY, sbox_data_o and sbox_inv_o SHALL be 0.
REQ-024 valid_o SHALL be high exactly in DONE; result_o and owner_o SHALL stay stable while valid_o && !ready_i.
REQ-025 In DONE with ready_i high, the next state SHALL be IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-026 Latency: grant in cycle 0, BUSY in cycles 1-4, valid_o high from cycle 5; with ready_i held high, throughput is one word per 6 cycles.
REQ-027 Requesters SHALL hold req and data until granted; deasserting req before the grant withdraws the request without side effects.
REQ-028 result_o bytes not yet written in the current operation SHALL retain their previous values; result_o is only observable in DONE.

Reset
REQ-029 Asserting rst_i SHALL immediately force IDLE, cnt=0, valid_o=0, busy_o=0, gnt_o=0, result_o=0, owner_o=0, sbox_data_o=0, sbox_inv_o=0, and set the last-grant pointer to 1 so requester 0 wins the first contest.
REQ-030 Reset during BUSY or DONE SHALL discard the in-flight word without producing valid_o; after release, normal arbitration resumes on the next edge.

Verification
REQ-031 The bench SHALL model the S-box with the AES forward/inverse tables and cover the following scenarios.
REQ-032 req_i=01, word0_i=0x00010203, inv0_i=0, ready_i=1 -> gnt_o=01 in cycle 0; sbox_data_o=03,02,01,00 in cycles 1-4; valid_o in cycle 5 with result_o=0x637C777B, owner_o=0.
REQ-033 req_i=10, word1_i=0x637C777B, inv1_i=1 -> result_o=0x00010203, owner_o=1.
REQ-034 req_i=11 held, ready_i=1, FAIR=1 -> grant sequence 01,10,01,10; with FAIR=0 -> 01,01,01.
REQ-035 Result presented with ready_i low for 3 cycles and req_i=11 -> valid_o, result_o and owner_o stable; gnt_o=00 throughout; IDLE on the cycle after ready_i rises.
REQ-036 rst_i pulsed during BUSY at cnt=2 -> all outputs 0 at once, no valid_o; a req_i=01 after release completes with the correct result.
